// File: rtl/enc32to5_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 32-to-5 request encoder.
// Consumers import this package rather than redefining widths locally.
package enc32to5_arbiter_pkg;

    localparam int ENC_W = 5;
    localparam int ENC_N = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Population count of a request-sized vector; result spans 0..32.
    function automatic logic [ENC_W:0] popcount32(input logic [ENC_N-1:0] v);
        logic [ENC_W:0] sum;
        sum = '0;
        for (int i = 0; i < ENC_N; i++) begin
            sum = sum + {{ENC_W{1'b0}}, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/enc32to5_arbiter_dec5to32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when en is low.
// The arbiter reuses it so its onehot output is derived from the encoded index.
module dec5to32
    import enc32to5_arbiter_pkg::*;
(
    input  logic [ENC_W-1:0] idx,
    input  logic             en,
    output logic [ENC_N-1:0] onehot
);

    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_dec
        assign onehot[gi] = en && (idx == ENC_W'(gi));
    end

endmodule

// File: rtl/enc32to5_arbiter_pri_search32.sv
// Combinational rotating priority search: lowest set bit of vec at or after base,
// wrapping 31 -> 0. With base tied to 0 this is a plain lowest-index-wins encoder.
module pri_search32
    import enc32to5_arbiter_pkg::*;
(
    input  logic [ENC_N-1:0] vec,
    input  logic [ENC_W-1:0] base,
    output logic             hit,
    output logic [ENC_W-1:0] pos
);

    logic [2*ENC_N-1:0] dbl;
    logic [ENC_N-1:0]   rot;
    logic [ENC_W-1:0]   off;

    // Doubling the vector turns the rotate-right into a plain part-select.
    assign dbl = {vec, vec};
    assign rot = dbl[base +: ENC_N];

    always_comb begin
        off = '0;
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ENC_W'(i);
            end
        end
    end

    assign hit = |vec;
    assign pos = base + off;

endmodule

// File: rtl/enc32to5_arbiter.sv
// Sequential 32-to-5 request encoder: sticky pending bits, masked eligibility,
// fixed or round-robin winner selection presented under a valid/ready handshake.
module enc32to5_arbiter
    import enc32to5_arbiter_pkg::*;
#(
    parameter int               ROUND_ROBIN = 0,
    parameter logic [ENC_N-1:0] RESET_MASK  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ENC_N-1:0] req,
    input  logic             mask_we,
    input  logic [ENC_N-1:0] mask_in,
    input  logic             ready,
    output logic             valid,
    output logic [ENC_W-1:0] idx,
    output logic [ENC_N-1:0] onehot,
    output logic [ENC_W:0]   pend_cnt
);

    state_t           state_reg,    state_next;
    logic [ENC_N-1:0] pending_reg,  pending_next;
    logic [ENC_N-1:0] mask_reg,     mask_next;
    logic [ENC_W-1:0] rr_ptr_reg,   rr_ptr_next;
    logic [ENC_W-1:0] idx_reg,      idx_next;
    logic             valid_reg,    valid_next;
    logic [ENC_W:0]   pend_cnt_reg, pend_cnt_next;

    logic [ENC_N-1:0] eligible;
    logic [ENC_N-1:0] clr;
    logic [ENC_W-1:0] search_base;
    logic             search_hit;
    logic [ENC_W-1:0] search_pos;

    assign eligible    = pending_reg & mask_reg;
    assign search_base = (ROUND_ROBIN != 0) ? rr_ptr_reg : '0;

    pri_search32 u_search (
        .vec  (eligible),
        .base (search_base),
        .hit  (search_hit),
        .pos  (search_pos)
    );

    // Only the currently granted line is cleared, and only on an accepted handshake.
    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_clr
        assign clr[gi] = valid_reg && ready && (idx_reg == ENC_W'(gi));
    end

    // A request arriving in the accept cycle wins over the clear, so it is never lost.
    assign pending_next  = req | (pending_reg & ~clr);
    assign mask_next     = mask_we ? mask_in : mask_reg;
    assign pend_cnt_next = popcount32(pending_next);

    always_comb begin
        state_next  = state_reg;
        valid_next  = valid_reg;
        idx_next    = idx_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (search_hit) begin
                    idx_next   = search_pos;
                    valid_next = 1'b1;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // idx/valid are frozen until the consumer accepts.
                if (ready) begin
                    valid_next = 1'b0;
                    state_next = ST_IDLE;
                    if (ROUND_ROBIN != 0) begin
                        rr_ptr_next = idx_reg + ENC_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            mask_reg     <= RESET_MASK;
            rr_ptr_reg   <= '0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            pend_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            mask_reg     <= mask_next;
            rr_ptr_reg   <= rr_ptr_next;
            idx_reg      <= idx_next;
            valid_reg    <= valid_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    dec5to32 u_dec (
        .idx    (idx_reg),
        .en     (valid_reg),
        .onehot (onehot)
    );

    assign valid    = valid_reg;
    assign idx      = idx_reg;
    assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_enc32to5_arbiter.sv
// Directed bench: a fixed-priority instance driven from a per-cycle vector table,
// plus a round-robin instance exercised with a hand-written wrap sequence.
module tb_enc32to5_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] req_fp, mask_in_fp;
    logic        mask_we_fp, ready_fp;
    logic        valid_fp;
    logic [4:0]  idx_fp;
    logic [31:0] onehot_fp;
    logic [5:0]  pend_cnt_fp;

    logic [31:0] req_rr, mask_in_rr;
    logic        mask_we_rr, ready_rr;
    logic        valid_rr;
    logic [4:0]  idx_rr;
    logic [31:0] onehot_rr;
    logic [5:0]  pend_cnt_rr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc32to5_arbiter #(.ROUND_ROBIN(0), .RESET_MASK(32'hFFFF_FFFF)) dut_fp (
        .clk      (clk),
        .reset    (reset),
        .req      (req_fp),
        .mask_we  (mask_we_fp),
        .mask_in  (mask_in_fp),
        .ready    (ready_fp),
        .valid    (valid_fp),
        .idx      (idx_fp),
        .onehot   (onehot_fp),
        .pend_cnt (pend_cnt_fp)
    );

    enc32to5_arbiter #(.ROUND_ROBIN(1), .RESET_MASK(32'hFFFF_FFFF)) dut_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req_rr),
        .mask_we  (mask_we_rr),
        .mask_in  (mask_in_rr),
        .ready    (ready_rr),
        .valid    (valid_rr),
        .idx      (idx_rr),
        .onehot   (onehot_rr),
        .pend_cnt (pend_cnt_rr)
    );

    typedef struct {
        logic [31:0] req;
        logic        mwe;
        logic [31:0] mask_in;
        logic        rdy;
        logic        v;
        logic [4:0]  idx;
        logic [31:0] oh;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic [31:0] r, input logic mwe, input logic [31:0] mi,
                       input logic rdy, input logic v, input logic [4:0] ix,
                       input logic [31:0] oh, input logic [5:0] cnt);
        vec_t e;
        e.req = r; e.mwe = mwe; e.mask_in = mi; e.rdy = rdy;
        e.v = v; e.idx = ix; e.oh = oh; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fp(input string tag, input logic v, input logic [4:0] ix,
                          input logic [31:0] oh, input logic [5:0] cnt);
        chk({tag, ".valid"},    {31'b0, valid_fp}, {31'b0, v});
        chk({tag, ".idx"},      {27'b0, idx_fp},   {27'b0, ix});
        chk({tag, ".onehot"},   onehot_fp,         oh);
        chk({tag, ".pend_cnt"}, {26'b0, pend_cnt_fp}, {26'b0, cnt});
        $display("txn %s valid=%0d idx=%0d onehot=%08h pend_cnt=%0d", tag, valid_fp, idx_fp, onehot_fp, pend_cnt_fp);
    endtask

    initial begin
        int rr_exp[6];
        rr_exp = '{0, 5, 31, 0, 5, 31};

        reset = 1'b1;
        req_fp = 32'hFFFF_FFFF; mask_we_fp = 1'b0; mask_in_fp = '0; ready_fp = 1'b0;
        req_rr = '0;            mask_we_rr = 1'b0; mask_in_rr = '0; ready_rr = 1'b0;

        // Reset held two cycles against all-ones requests.
        step(); chk_fp("rst0", 1'b0, 5'd0, 32'h0, 6'd0);
        step(); chk_fp("rst1", 1'b0, 5'd0, 32'h0, 6'd0);
        reset = 1'b0;
        step(); chk_fp("rel0", 1'b0, 5'd0, 32'h0, 6'd32);
        req_fp = '0;
        step(); chk_fp("rel1", 1'b1, 5'd0, 32'h1, 6'd32);
        reset = 1'b1;
        step(); chk_fp("rst2", 1'b0, 5'd0, 32'h0, 6'd0);
        reset = 1'b0;

        // Fixed priority: one pulse of bits 2,4,31, ready always high.
        row(32'h8000_0014, 0, 0, 1, 0, 0,  32'h0,         3);
        row(32'h0,         0, 0, 1, 1, 2,  32'h4,         3);
        row(32'h0,         0, 0, 1, 0, 2,  32'h0,         2);
        row(32'h0,         0, 0, 1, 1, 4,  32'h10,        2);
        row(32'h0,         0, 0, 1, 0, 4,  32'h0,         1);
        row(32'h0,         0, 0, 1, 1, 31, 32'h8000_0000, 1);
        row(32'h0,         0, 0, 1, 0, 31, 32'h0,         0);
        // Backpressure on idx 7 for 10 cycles, req[3] pulsing, mask rewritten mid-grant.
        row(32'h80,        0, 0, 0, 0, 31, 32'h0,         1);
        row(32'h0,         0, 0, 0, 1, 7,  32'h80,        1);
        row(32'h8,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h0,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h8,         1, 32'hFFFF_FF7F, 0, 1, 7, 32'h80, 2);
        row(32'h0,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h8,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h0,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h8,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h0,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h8,         0, 0, 0, 1, 7,  32'h80,        2);
        row(32'h0,         0, 0, 1, 0, 7,  32'h0,         1);
        row(32'h0,         0, 0, 1, 1, 3,  32'h8,         1);
        row(32'h0,         0, 0, 1, 0, 3,  32'h0,         0);
        // Request on bit 9 coinciding with its own accept.
        row(32'h200,       0, 0, 0, 0, 3,  32'h0,         1);
        row(32'h0,         0, 0, 0, 1, 9,  32'h200,       1);
        row(32'h200,       0, 0, 1, 0, 9,  32'h0,         1);
        row(32'h0,         0, 0, 0, 1, 9,  32'h200,       1);
        row(32'h0,         0, 0, 1, 0, 9,  32'h0,         0);
        // Masked bit 0 keeps accumulating until the mask is restored.
        row(32'h3,         1, 32'hFFFF_FFFE, 0, 0, 9, 32'h0, 2);
        row(32'h0,         0, 0, 1, 1, 1,  32'h2,         2);
        row(32'h0,         0, 0, 1, 0, 1,  32'h0,         1);
        row(32'h0,         0, 0, 1, 0, 1,  32'h0,         1);
        row(32'h0,         0, 0, 1, 0, 1,  32'h0,         1);
        row(32'h0,         1, 32'hFFFF_FFFF, 1, 0, 1, 32'h0, 1);
        row(32'h0,         0, 0, 1, 1, 0,  32'h1,         1);
        row(32'h0,         0, 0, 1, 0, 0,  32'h0,         0);

        for (int i = 0; i < tbl.size(); i++) begin
            req_fp     = tbl[i].req;
            mask_we_fp = tbl[i].mwe;
            mask_in_fp = tbl[i].mask_in;
            ready_fp   = tbl[i].rdy;
            step();
            chk_fp($sformatf("row%0d", i), tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].cnt);
        end
        req_fp = '0; mask_we_fp = 1'b0; ready_fp = 1'b0;

        // Round robin: bits 0,5,31 held high, ready high; expect wrap 31 -> 0.
        req_rr   = 32'h8000_0021;
        ready_rr = 1'b1;
        step();
        chk("rr.start.valid", {31'b0, valid_rr}, 32'h0);
        chk("rr.start.pend_cnt", {26'b0, pend_cnt_rr}, 32'd3);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rr%0d.valid", k), {31'b0, valid_rr}, 32'h1);
            chk($sformatf("rr%0d.idx", k), {27'b0, idx_rr}, rr_exp[k]);
            chk($sformatf("rr%0d.onehot", k), onehot_rr, 32'h1 << rr_exp[k]);
            $display("txn rr%0d valid=%0d idx=%0d onehot=%08h pend_cnt=%0d", k, valid_rr, idx_rr, onehot_rr, pend_cnt_rr);
            step();
            chk($sformatf("rr%0d.gap", k), {31'b0, valid_rr}, 32'h0);
            chk($sformatf("rr%0d.pend_cnt", k), {26'b0, pend_cnt_rr}, 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
